stage_reg_skid: RTL and testbench

- Parametrised pipeline-stage register for the OpenMIPS core. It generalises the fixed MEM/WB latch into a reusable stage that carries any payload width.
- Replaces the global stall vector with per-stage valid/ready handshakes. Adds an optional 2-entry skid buffer, a flush input and a saturating back-pressure counter.
- Sits between any two pipeline stages, e.g. MEM->WB with a 143-bit payload: wd 5, wreg 1, wdata 32, hi 32, lo 32, whilo 1, cp0_we 1, cp0_addr 5, cp0_data 32, LLbit_we 1, LLbit_value 1.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/sat_counter.sv | 28 ++
 rtl/stage_reg_skid.sv | 138 +++++++++++++
 tb/tb_stage_reg_skid.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions used by the OpenMIPS stage registers.
// Contents:
//   MEM_WB_PAYLOAD_W : width of the MEM->WB bundle (143 bits)
//   mem_wb_payload_t : MEM->WB bundle, MSB-first field order
//   MEM_WB_NOP       : all-zero bubble (every write-enable low)
//   occ_e            : stage occupancy / FSM state encoding
package pipe_pkg;

  localparam int MEM_WB_PAYLOAD_W = 143;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_data;
    logic        LLbit_we;
    logic        LLbit_value;
  } mem_wb_payload_t;

  localparam mem_wb_payload_t MEM_WB_NOP = '0;

  // The stage state doubles as its occupancy count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears cnt)
//   inc      : add one this cycle unless already at all-ones
//   clr      : load zero; wins over inc
//   cnt      : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Clear beats increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stage_reg_skid.sv
// Parametrised valid/ready pipeline-stage register with optional 2-entry
// skid buffer, flush and a saturating back-pressure counter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (drops all entries)
//   flush        : discard every held entry and any same-cycle input
//   up_valid/up_ready/up_data : upstream handshake and payload
//   dn_valid/dn_ready/dn_data : downstream handshake and payload
//                               (dn_data is NOP_PAYLOAD while dn_valid=0)
//   occupancy    : number of held entries (0..2)
//   stall_cycles : saturating count of cycles with dn_valid & ~dn_ready
//   clr_cnt      : synchronous clear of stall_cycles
module stage_reg_skid
  import pipe_pkg::*;
#(
  parameter int                   PAYLOAD_W   = MEM_WB_PAYLOAD_W,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
  parameter int                   SKID_EN     = 1,
  parameter int                   CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [PAYLOAD_W-1:0] up_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [PAYLOAD_W-1:0] dn_data,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cycles,
  input  logic                 clr_cnt
);

  occ_e                 r_state;
  occ_e                 w_state_nxt;
  logic [PAYLOAD_W-1:0] r_main;
  logic [PAYLOAD_W-1:0] r_skid;
  logic                 r_up_ready;
  logic                 w_main_v;
  logic                 w_up_fire;
  logic                 w_dn_fire;
  logic                 w_load_main;
  logic                 w_load_skid;
  logic                 w_main_from_skid;

  assign w_main_v  = (r_state != OCC_EMPTY);
  assign w_up_fire = up_valid & up_ready;
  assign w_dn_fire = w_main_v & dn_ready;

  // With the skid buffer the ready is a flop so dn_ready never reaches
  // up_ready combinationally; without it the stage accepts whenever its
  // single slot is free or is being drained this cycle.
  generate
    if (SKID_EN != 0) begin : g_skid
      assign up_ready = r_up_ready;
    end else begin : g_noskid
      assign up_ready = ~w_main_v | dn_ready;
    end
  endgenerate

  // Next-state and data-steering decisions. Flush simply forces EMPTY: a
  // dn_fire in that cycle has already been sampled downstream, and any
  // up_fire is dropped because no load strobe is raised.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_up_fire) begin
            w_state_nxt = OCC_ONE;
            w_load_main = 1'b1;
          end
        end
        OCC_ONE: begin
          if (w_up_fire && w_dn_fire) begin
            w_load_main = 1'b1;
          end else if (w_up_fire && (SKID_EN != 0)) begin
            w_state_nxt = OCC_FULL;
            w_load_skid = 1'b1;
          end else if (w_dn_fire) begin
            w_state_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (w_dn_fire) begin
            w_state_nxt      = OCC_ONE;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = OCC_EMPTY;
      endcase
    end
  end

  // State register; the registered ready mirrors "next state is not FULL".
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= OCC_EMPTY;
      r_up_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_up_ready <= (w_state_nxt != OCC_FULL);
    end
  end

  // Payload storage carries no reset: stale contents are never exposed
  // because dn_data is masked whenever main is invalid.
  always_ff @(posedge clk) begin
    if (w_load_main) begin
      r_main <= up_data;
    end else if (w_main_from_skid) begin
      r_main <= r_skid;
    end
    if (w_load_skid) begin
      r_skid <= up_data;
    end
  end

  assign dn_valid  = w_main_v;
  assign dn_data   = w_main_v ? r_main : NOP_PAYLOAD;
  assign occupancy = r_state;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_main_v & ~dn_ready),
    .clr (clr_cnt),
    .cnt (stall_cycles)
  );

endmodule

// File: tb/tb_stage_reg_skid.sv
// Self-checking bench for stage_reg_skid. Three instances share clk/rst:
//   u_dut   : default parameters (143-bit payload, skid buffer, 16-bit counter)
//   u_dutNs : SKID_EN=0, 16-bit payload
//   u_dutC4 : CNT_W=4, 16-bit payload
// Accepted payloads of u_dut go into a scoreboard queue and are popped and
// compared whenever u_dut completes a downstream transfer.
module tb_stage_reg_skid;
  import pipe_pkg::*;

  logic         clk = 1'b0;
  logic         rst;

  logic         flush, upValid, upReady, dnValid, dnReady, clrCnt;
  logic [142:0] upData, dnData;
  logic [1:0]   occ;
  logic [15:0]  stallCnt;

  logic         nsFlush, nsUpValid, nsUpReady, nsDnValid, nsDnReady, nsClrCnt;
  logic [15:0]  nsUpData, nsDnData, nsStall;
  logic [1:0]   nsOcc;

  logic         c4Flush, c4UpValid, c4UpReady, c4DnValid, c4DnReady, c4ClrCnt;
  logic [15:0]  c4UpData, c4DnData;
  logic [3:0]   c4Stall;
  logic [1:0]   c4Occ;

  logic [142:0] sbQ[$];
  logic         obsDnFire;
  logic [142:0] obsDnData;
  logic [142:0] expData;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  stage_reg_skid u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(upValid), .up_ready(upReady), .up_data(upData),
    .dn_valid(dnValid), .dn_ready(dnReady), .dn_data(dnData),
    .occupancy(occ), .stall_cycles(stallCnt), .clr_cnt(clrCnt)
  );

  stage_reg_skid #(.PAYLOAD_W(16), .SKID_EN(0)) u_dutNs (
    .clk(clk), .rst(rst), .flush(nsFlush),
    .up_valid(nsUpValid), .up_ready(nsUpReady), .up_data(nsUpData),
    .dn_valid(nsDnValid), .dn_ready(nsDnReady), .dn_data(nsDnData),
    .occupancy(nsOcc), .stall_cycles(nsStall), .clr_cnt(nsClrCnt)
  );

  stage_reg_skid #(.PAYLOAD_W(16), .CNT_W(4)) u_dutC4 (
    .clk(clk), .rst(rst), .flush(c4Flush),
    .up_valid(c4UpValid), .up_ready(c4UpReady), .up_data(c4UpData),
    .dn_valid(c4DnValid), .dn_ready(c4DnReady), .dn_data(c4DnData),
    .occupancy(c4Occ), .stall_cycles(c4Stall), .clr_cnt(c4ClrCnt)
  );

  // Advance one clock. Handshakes are observed at the falling edge, away
  // from the active edge; accepted payloads of u_dut enter the scoreboard.
  task automatic step();
    @(negedge clk);
    obsDnFire = dnValid & dnReady;
    obsDnData = dnData;
    if (upValid && upReady && !flush && !rst) sbQ.push_back(upData);
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expected payload; an empty queue yields an impossible value.
  task automatic popExpected();
    if (sbQ.size() > 0) expData = sbQ.pop_front();
    else expData = {143{1'b1}};
  endtask

  task automatic test_reset();
    flush = 0; upValid = 0; upData = '0; dnReady = 0; clrCnt = 0;
    nsFlush = 0; nsUpValid = 0; nsUpData = '0; nsDnReady = 0; nsClrCnt = 0;
    c4Flush = 0; c4UpValid = 0; c4UpData = '0; c4DnReady = 0; c4ClrCnt = 0;
    rst = 1;
    step(); step();
    rst = 0;
    sbQ.delete();
    checks++; if (dnValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_dn_valid got=%0b exp=0", dnValid); end
    checks++; if (dnData !== MEM_WB_NOP) begin failures++; $display("[TB] FAIL reset_dn_data got=%0h exp=0", dnData); end
    checks++; if (occ !== 2'd0) begin failures++; $display("[TB] FAIL reset_occ got=%0d exp=0", occ); end
    checks++; if (upReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_up_ready got=%0b exp=1", upReady); end
    checks++; if (stallCnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_stall got=%0d exp=0", stallCnt); end
    checks++; if (nsUpReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_ns_up_ready got=%0b exp=1", nsUpReady); end
  endtask

  task automatic test_stream();
    dnReady = 1;
    for (int k = 1; k <= 3; k++) begin
      upValid = 1; upData = 143'(k);
      step();
      if (k > 1) begin
        checks++; if (obsDnFire !== 1'b1) begin failures++; $display("[TB] FAIL stream_dn_fire%0d got=%0b exp=1", k-1, obsDnFire); end
        popExpected();
        checks++; if (obsDnData !== expData) begin failures++; $display("[TB] FAIL stream_data%0d got=%0h exp=%0h", k-1, obsDnData, expData); end
      end
      checks++; if (dnData !== 143'(k)) begin failures++; $display("[TB] FAIL stream_latency%0d got=%0h exp=%0h", k, dnData, k); end
      checks++; if (occ !== 2'd1) begin failures++; $display("[TB] FAIL stream_occ%0d got=%0d exp=1", k, occ); end
    end
    upValid = 0;
    step();
    popExpected();
    checks++; if (obsDnFire !== 1'b1 || obsDnData !== expData || expData !== 143'd3) begin failures++; $display("[TB] FAIL stream_last got=%0h exp=3", obsDnData); end
    checks++; if (occ !== 2'd0) begin failures++; $display("[TB] FAIL stream_drained_occ got=%0d exp=0", occ); end
    checks++; if (stallCnt !== 16'd0) begin failures++; $display("[TB] FAIL stream_stall got=%0d exp=0", stallCnt); end
  endtask

  task automatic test_skid();
    dnReady = 0;
    upValid = 1; upData = 143'hA;
    step();
    checks++; if (upReady !== 1'b1) begin failures++; $display("[TB] FAIL skid_ready_one got=%0b exp=1", upReady); end
    upData = 143'hB;
    step();
    upValid = 0;
    checks++; if (occ !== 2'd2) begin failures++; $display("[TB] FAIL skid_occ_full got=%0d exp=2", occ); end
    checks++; if (upReady !== 1'b0) begin failures++; $display("[TB] FAIL skid_ready_full got=%0b exp=0", upReady); end
    checks++; if (dnData !== 143'hA) begin failures++; $display("[TB] FAIL skid_head got=%0h exp=a", dnData); end
    dnReady = 1;
    step();
    popExpected();
    checks++; if (obsDnFire !== 1'b1 || obsDnData !== expData || expData !== 143'hA) begin failures++; $display("[TB] FAIL skid_first got=%0h exp=a", obsDnData); end
    checks++; if (upReady !== 1'b1) begin failures++; $display("[TB] FAIL skid_ready_after got=%0b exp=1", upReady); end
    checks++; if (occ !== 2'd1) begin failures++; $display("[TB] FAIL skid_occ_one got=%0d exp=1", occ); end
    step();
    popExpected();
    checks++; if (obsDnFire !== 1'b1 || obsDnData !== expData || expData !== 143'hB) begin failures++; $display("[TB] FAIL skid_second got=%0h exp=b", obsDnData); end
    // Exactly one stalled cycle: B offered while A sat in main with dn_ready low.
    checks++; if (stallCnt !== 16'd1) begin failures++; $display("[TB] FAIL skid_stall got=%0d exp=1", stallCnt); end
  endtask

  task automatic test_flush();
    dnReady = 0;
    upValid = 1; upData = 143'h11; step();
    upData = 143'h12; step();
    checks++; if (occ !== 2'd2) begin failures++; $display("[TB] FAIL flush_prefill got=%0d exp=2", occ); end
    flush = 1; upData = 143'h13;
    step();
    flush = 0; upValid = 0;
    sbQ.delete();
    checks++; if (occ !== 2'd0) begin failures++; $display("[TB] FAIL flush_full_occ got=%0d exp=0", occ); end
    checks++; if (dnValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_full_valid got=%0b exp=0", dnValid); end
    checks++; if (dnData !== MEM_WB_NOP) begin failures++; $display("[TB] FAIL flush_full_data got=%0h exp=0", dnData); end
    checks++; if (upReady !== 1'b1) begin failures++; $display("[TB] FAIL flush_full_ready got=%0b exp=1", upReady); end
    // 1 from before, +1 while 0x12 was offered, +1 for the stalled flush cycle; not cleared.
    checks++; if (stallCnt !== 16'd3) begin failures++; $display("[TB] FAIL flush_stall_kept got=%0d exp=3", stallCnt); end
    upValid = 1; upData = 143'h21; step();
    flush = 1; upData = 143'h22;
    step();
    flush = 0; upValid = 0;
    sbQ.delete();
    checks++; if (occ !== 2'd0 || dnValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_one_discard got=%0d exp=0", occ); end
    checks++; if (stallCnt !== 16'd4) begin failures++; $display("[TB] FAIL flush_one_stall got=%0d exp=4", stallCnt); end
    dnReady = 1; upValid = 1; upData = 143'h23;
    step();
    upValid = 0;
    checks++; if (dnData !== 143'h23) begin failures++; $display("[TB] FAIL flush_recover got=%0h exp=23", dnData); end
    step();
    popExpected();
    checks++; if (obsDnData !== expData || expData !== 143'h23) begin failures++; $display("[TB] FAIL flush_recover_pop got=%0h exp=23", obsDnData); end
  endtask

  task automatic test_saturate();
    c4DnReady = 0; c4UpValid = 1; c4UpData = 16'h9;
    step();
    c4UpValid = 0;
    checks++; if (c4Stall !== 4'd0 || c4Occ !== 2'd1) begin failures++; $display("[TB] FAIL sat_start got=%0d exp=0", c4Stall); end
    repeat (14) step();
    checks++; if (c4Stall !== 4'd14) begin failures++; $display("[TB] FAIL sat_14 got=%0d exp=14", c4Stall); end
    repeat (6) step();
    checks++; if (c4Stall !== 4'd15) begin failures++; $display("[TB] FAIL sat_hold got=%0d exp=15", c4Stall); end
    checks++; if (c4DnData !== 16'h9) begin failures++; $display("[TB] FAIL sat_data got=%0h exp=9", c4DnData); end
    c4ClrCnt = 1; step(); c4ClrCnt = 0;
    checks++; if (c4Stall !== 4'd0) begin failures++; $display("[TB] FAIL sat_clr got=%0d exp=0", c4Stall); end
    step();
    checks++; if (c4Stall !== 4'd1) begin failures++; $display("[TB] FAIL sat_restart got=%0d exp=1", c4Stall); end
    c4DnReady = 1; step();
    checks++; if (c4DnValid !== 1'b0 || c4Stall !== 4'd1) begin failures++; $display("[TB] FAIL sat_drain got=%0d exp=1", c4Stall); end
  endtask

  task automatic test_noskid();
    nsDnReady = 0; nsUpValid = 1; nsUpData = 16'h5;
    step();
    checks++; if (nsDnData !== 16'h5 || nsOcc !== 2'd1) begin failures++; $display("[TB] FAIL ns_hold got=%0h exp=5", nsDnData); end
    checks++; if (nsUpReady !== 1'b0) begin failures++; $display("[TB] FAIL ns_ready_low got=%0b exp=0", nsUpReady); end
    nsUpData = 16'h6;
    step();
    checks++; if (nsDnData !== 16'h5 || nsOcc !== 2'd1) begin failures++; $display("[TB] FAIL ns_no_second got=%0h exp=5", nsDnData); end
    nsDnReady = 1;
    #1;
    checks++; if (nsUpReady !== 1'b1) begin failures++; $display("[TB] FAIL ns_ready_comb got=%0b exp=1", nsUpReady); end
    step();
    nsUpValid = 0;
    checks++; if (nsDnData !== 16'h6 || nsOcc !== 2'd1) begin failures++; $display("[TB] FAIL ns_swap got=%0h exp=6", nsDnData); end
    step();
    checks++; if (nsOcc !== 2'd0 || nsDnData !== 16'h0) begin failures++; $display("[TB] FAIL ns_drain got=%0h exp=0", nsDnData); end
  endtask

  task automatic test_reset_full();
    dnReady = 0; upValid = 1; upData = 143'h31; step();
    upData = 143'h32; step();
    upValid = 0;
    checks++; if (occ !== 2'd2 || stallCnt !== 16'd5) begin failures++; $display("[TB] FAIL rstfull_pre got=%0d exp=5", stallCnt); end
    rst = 1; step(); rst = 0;
    sbQ.delete();
    checks++; if (occ !== 2'd0 || dnValid !== 1'b0) begin failures++; $display("[TB] FAIL rstfull_empty got=%0d exp=0", occ); end
    checks++; if (stallCnt !== 16'd0) begin failures++; $display("[TB] FAIL rstfull_stall got=%0d exp=0", stallCnt); end
    dnReady = 1; upValid = 1; upData = 143'h7;
    step();
    upValid = 0;
    checks++; if (dnValid !== 1'b1 || dnData !== 143'h7) begin failures++; $display("[TB] FAIL rstfull_next got=%0h exp=7", dnData); end
    step();
    popExpected();
    checks++; if (obsDnData !== expData || expData !== 143'h7) begin failures++; $display("[TB] FAIL rstfull_pop got=%0h exp=7", obsDnData); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_saturate();
    test_noskid();
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
